// File: rtl/data_mem_ctr_pkg.sv
// Shared definitions for the stage-4 data-memory controller: memory op codes,
// FSM states, func_3 access codes and the request legality decoder.
package data_mem_ctr_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    localparam logic MEM_OP_LOAD  = 1'b0;
    localparam logic MEM_OP_STORE = 1'b1;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    typedef struct packed {
        logic  legal;
        size_t size;
    } access_t;

    // Classify a request: access size, and whether the code is known and the address aligned to it
    function automatic access_t decodeAccess(input logic op, input logic [2:0] f3, input logic [1:0] addrLo);
        access_t acc;
        acc.size  = SZ_BYTE;
        acc.legal = 1'b0;
        if (op == MEM_OP_LOAD) begin
            case (f3)
                F3_LB, F3_LBU: begin acc.size = SZ_BYTE; acc.legal = 1'b1;              end
                F3_LH, F3_LHU: begin acc.size = SZ_HALF; acc.legal = ~addrLo[0];        end
                F3_LW:         begin acc.size = SZ_WORD; acc.legal = (addrLo == 2'b00); end
                default: ;
            endcase
        end else begin
            case (f3)
                F3_SB: begin acc.size = SZ_BYTE; acc.legal = 1'b1;              end
                F3_SH: begin acc.size = SZ_HALF; acc.legal = ~addrLo[0];        end
                F3_SW: begin acc.size = SZ_WORD; acc.legal = (addrLo == 2'b00); end
                default: ;
            endcase
        end
        return acc;
    endfunction

endpackage

// File: rtl/data_mem_ctr_ram.sv
// Single-port synchronous data RAM with per-byte write enables and a
// registered read port. Contents are deliberately not reset.
module mem_ctr_ram
    import data_mem_ctr_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [BE_W-1:0]   i_we,
    input  logic              i_re,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // Byte-lane writes and registered read of the addressed word
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_ctr.sv
// Data-memory responder for the stage-4 load/store port: latches one request,
// waits LATENCY cycles, performs the RAM access on the last wait cycle and
// returns a lane-aligned, zero-extended read word (or an error) for one cycle.
module data_mem_ctr
    import data_mem_ctr_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_func_3,
    output logic        o_resp_valid,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic        o_busy
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            r_state;
    state_t            w_nextState;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_op;
    logic [1:0]        r_addrLo;
    logic [ADDR_W-1:0] r_wordIdx;
    size_t             r_size;
    logic [31:0]       r_wdata;
    logic              r_err;

    access_t           w_acc;
    logic              w_accept;
    logic              w_finalWait;
    logic [3:0]        w_we;
    logic              w_re;
    logic [31:0]       w_ramWdata;
    logic [31:0]       w_ramRdata;
    logic [31:0]       w_shifted;
    logic              w_unused_addr;

    assign w_acc         = decodeAccess(i_op, i_func_3, i_addr[1:0]);
    assign w_accept      = i_req_valid && (r_state == ST_IDLE);
    assign w_finalWait   = (r_state == ST_WAIT) && (r_cnt == '0);
    assign w_re          = w_finalWait && (r_op == MEM_OP_LOAD) && !rst;
    assign w_unused_addr = ^i_addr[31:ADDR_W+2];

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next state: illegal requests skip WAIT and answer immediately
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_nextState = w_acc.legal ? ST_WAIT : ST_RESP;
            ST_WAIT: if (r_cnt == '0) w_nextState = ST_RESP;
            ST_RESP: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Capture the request at accept and count down the wait cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_op      <= MEM_OP_LOAD;
            r_addrLo  <= 2'b00;
            r_wordIdx <= '0;
            r_size    <= SZ_BYTE;
            r_wdata   <= '0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= CNT_LOAD;
            r_op      <= i_op;
            r_addrLo  <= i_addr[1:0];
            r_wordIdx <= i_addr[ADDR_W+1:2];
            r_size    <= w_acc.size;
            r_wdata   <= i_wdata;
            r_err     <= ~w_acc.legal;
        end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end else if (r_state == ST_RESP) begin
            r_err <= 1'b0;
        end
    end

    // Byte enables and lane-replicated store data; a reset in the commit cycle kills the write
    always_comb begin
        w_we       = 4'b0000;
        w_ramWdata = r_wdata;
        case (r_size)
            SZ_BYTE: begin
                w_we       = 4'b0001 << r_addrLo;
                w_ramWdata = {4{r_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_we       = 4'b0011 << r_addrLo;
                w_ramWdata = {2{r_wdata[15:0]}};
            end
            default: begin
                w_we       = 4'b1111;
                w_ramWdata = r_wdata;
            end
        endcase
        if (!(w_finalWait && (r_op == MEM_OP_STORE) && !rst)) begin
            w_we = 4'b0000;
        end
    end

    mem_ctr_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_addr  (r_wordIdx),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_wdata (w_ramWdata),
        .o_rdata (w_ramRdata)
    );

    // FSM outputs: handshake, busy, and the lane-aligned response while in RESP
    always_comb begin
        o_req_ready  = 1'b0;
        o_busy       = 1'b1;
        o_resp_valid = 1'b0;
        o_err        = 1'b0;
        o_rdata      = 32'h0;
        w_shifted    = w_ramRdata >> {r_addrLo, 3'b000};
        case (r_state)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                o_busy      = 1'b0;
            end
            ST_RESP: begin
                o_resp_valid = 1'b1;
                o_err        = r_err;
                if (!r_err && (r_op == MEM_OP_LOAD)) begin
                    case (r_size)
                        SZ_BYTE: o_rdata = {24'h0, w_shifted[7:0]};
                        SZ_HALF: o_rdata = {16'h0, w_shifted[15:0]};
                        default: o_rdata = w_shifted;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_data_mem_ctr.sv
// Self-checking bench for data_mem_ctr: one instance with LATENCY=1 and one
// with LATENCY=3, directed vector table, reset corner sequences, a held
// back-to-back request stream, and random traffic against a byte-array model.
module tb_data_mem_ctr;

    typedef struct {
        logic        op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
        int          expLat;
        string       tag;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic        reqValid  [2];
    logic        reqReady  [2];
    logic        op        [2];
    logic [31:0] addr      [2];
    logic [31:0] wdata     [2];
    logic [2:0]  f3        [2];
    logic        respValid [2];
    logic [31:0] rdata     [2];
    logic        err       [2];
    logic        busy      [2];

    int checks = 0;
    int errors = 0;

    logic [7:0] modelMem [2][4096];

    always #5 clk = ~clk;

    data_mem_ctr #(.ADDR_W(10), .LATENCY(1)) dut0 (
        .clk(clk), .rst(rst[0]), .i_req_valid(reqValid[0]), .o_req_ready(reqReady[0]),
        .i_op(op[0]), .i_addr(addr[0]), .i_wdata(wdata[0]), .i_func_3(f3[0]),
        .o_resp_valid(respValid[0]), .o_rdata(rdata[0]), .o_err(err[0]), .o_busy(busy[0])
    );

    data_mem_ctr #(.ADDR_W(10), .LATENCY(3)) dut1 (
        .clk(clk), .rst(rst[1]), .i_req_valid(reqValid[1]), .o_req_ready(reqReady[1]),
        .i_op(op[1]), .i_addr(addr[1]), .i_wdata(wdata[1]), .i_func_3(f3[1]),
        .o_resp_valid(respValid[1]), .o_rdata(rdata[1]), .o_err(err[1]), .o_busy(busy[1])
    );

    function automatic int latOf(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte-addressed reference: size from func_3, natural alignment, 4 KiB wrap
    task automatic modelRun(input int d, input logic o, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] w, output logic [31:0] expR, output logic expE);
        int size;
        int base;
        size = 0;
        if (o == 1'b0) begin
            case (f)
                3'd0, 3'd4: size = 1;
                3'd1, 3'd5: size = 2;
                3'd2:       size = 4;
                default:    size = 0;
            endcase
        end else begin
            case (f)
                3'd0:    size = 1;
                3'd1:    size = 2;
                3'd2:    size = 4;
                default: size = 0;
            endcase
        end
        expR = 32'h0;
        expE = 1'b0;
        base = int'(a % 32'd4096);
        if (size == 0 || (a % size) != 0) begin
            expE = 1'b1;
        end else if (o == 1'b1) begin
            for (int i = 0; i < size; i++) modelMem[d][base + i] = w[8*i +: 8];
        end else begin
            for (int i = 0; i < size; i++) expR = expR | (32'(modelMem[d][base + i]) << (8 * i));
        end
    endtask

    // One full request/response transaction with latency, data and pulse-width checks
    task automatic applyStimulus(input int d, input logic o, input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] w, input logic [31:0] expR, input logic expE,
                                 input int expLat, input string tag);
        int  lat;
        bit  seen;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (reqReady[d]) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checkOutput({tag, " ready timeout"}, 32'(reqReady[d]), 32'd1);
            return;
        end
        op[d] = o; f3[d] = f; addr[d] = a; wdata[d] = w; reqValid[d] = 1'b1;
        @(negedge clk);
        reqValid[d] = 1'b0;
        lat  = 1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (respValid[d]) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        if (!seen) begin
            checkOutput({tag, " resp timeout"}, 32'(respValid[d]), 32'd1);
            return;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, " rdata"}, rdata[d], expR);
        checkOutput({tag, " err"}, 32'(err[d]), 32'(expE));
        @(negedge clk);
        checkOutput({tag, " pulse end"}, 32'(respValid[d]), 32'd0);
        checkOutput({tag, " rdata cleared"}, rdata[d], 32'h0);
        checkOutput({tag, " ready after"}, 32'(reqReady[d]), 32'd1);
    endtask

    // Three loads with valid held high on the LATENCY=3 instance, including aliased addresses
    task automatic runBackToBack();
        logic [31:0] reqAddr [3];
        logic [31:0] expData [3];
        int          acc [3];
        int          reqIdx;
        int          respIdx;
        int          last;
        reqAddr = '{32'h10, 32'h1014, 32'h1010};
        expData = '{32'hA5A50F0F, 32'h01234567, 32'hA5A50F0F};
        reqIdx  = 0;
        respIdx = 0;
        last    = -100;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (respValid[1]) begin
                if (respIdx < 3) begin
                    checkOutput("b2b rdata", rdata[1], expData[respIdx]);
                    checkOutput("b2b resp latency", 32'(c - acc[respIdx]), 32'(latOf(1) + 1));
                end else begin
                    checkOutput("b2b extra response", 32'(respIdx), 32'd2);
                end
                respIdx++;
            end
            if (c - last < latOf(1) + 2) checkOutput("b2b ready low while busy", 32'(reqReady[1]), 32'd0);
            if (reqIdx < 3) begin
                op[1] = 1'b0; f3[1] = 3'b010; addr[1] = reqAddr[reqIdx]; wdata[1] = 32'h0;
                reqValid[1] = 1'b1;
                if (reqReady[1]) begin
                    acc[reqIdx] = c;
                    if (reqIdx > 0) checkOutput("b2b accept spacing", 32'(c - acc[reqIdx-1]), 32'(latOf(1) + 2));
                    last = c;
                    reqIdx++;
                end
            end else begin
                reqValid[1] = 1'b0;
            end
        end
        checkOutput("b2b response count", 32'(respIdx), 32'd3);
        checkOutput("b2b accept count", 32'(reqIdx), 32'd3);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] expR;
        logic        expE;
        logic        ro;
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rw;

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; reqValid[d] = 1'b0; op[d] = 1'b0;
            addr[d] = 32'h0; wdata[d] = 32'h0; f3[d] = 3'b000;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput("reset ready", 32'(reqReady[d]), 32'd1);
            checkOutput("reset busy", 32'(busy[d]), 32'd0);
            checkOutput("reset resp_valid", 32'(respValid[d]), 32'd0);
            checkOutput("reset rdata", rdata[d], 32'h0);
            checkOutput("reset err", 32'(err[d]), 32'd0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Directed vectors on the LATENCY=1 instance
        vecs.push_back('{1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 2, "SW 0x10"});
        vecs.push_back('{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 2, "LW 0x10"});
        vecs.push_back('{1'b1, 3'b010, 32'h10,   32'h11223344, 32'h0,        1'b0, 2, "SW 0x10 base"});
        vecs.push_back('{1'b1, 3'b000, 32'h13,   32'h000000AA, 32'h0,        1'b0, 2, "SB 0x13"});
        vecs.push_back('{1'b0, 3'b010, 32'h10,   32'h0,        32'hAA223344, 1'b0, 2, "LW after SB"});
        vecs.push_back('{1'b0, 3'b000, 32'h13,   32'h0,        32'h000000AA, 1'b0, 2, "LB 0x13"});
        vecs.push_back('{1'b1, 3'b001, 32'h12,   32'h0000BEEF, 32'h0,        1'b0, 2, "SH 0x12"});
        vecs.push_back('{1'b0, 3'b101, 32'h12,   32'h0,        32'h0000BEEF, 1'b0, 2, "LHU 0x12"});
        vecs.push_back('{1'b0, 3'b001, 32'h11,   32'h0,        32'h0,        1'b1, 1, "LH 0x11 misaligned"});
        vecs.push_back('{1'b1, 3'b010, 32'h04,   32'h01020304, 32'h0,        1'b0, 2, "SW 0x04"});
        vecs.push_back('{1'b1, 3'b010, 32'h06,   32'h55555555, 32'h0,        1'b1, 1, "SW 0x06 misaligned"});
        vecs.push_back('{1'b0, 3'b010, 32'h04,   32'h0,        32'h01020304, 1'b0, 2, "LW 0x04 unchanged"});
        vecs.push_back('{1'b0, 3'b011, 32'h04,   32'h0,        32'h0,        1'b1, 1, "load f3 011"});
        vecs.push_back('{1'b0, 3'b110, 32'h04,   32'h0,        32'h0,        1'b1, 1, "load f3 110"});
        vecs.push_back('{1'b1, 3'b011, 32'h04,   32'hFFFFFFFF, 32'h0,        1'b1, 1, "store f3 011"});
        vecs.push_back('{1'b1, 3'b111, 32'h04,   32'hFFFFFFFF, 32'h0,        1'b1, 1, "store f3 111"});
        vecs.push_back('{1'b0, 3'b010, 32'h04,   32'h0,        32'h01020304, 1'b0, 2, "LW 0x04 after bad stores"});
        vecs.push_back('{1'b0, 3'b100, 32'h12,   32'h0,        32'h000000EF, 1'b0, 2, "LBU 0x12"});
        vecs.push_back('{1'b0, 3'b001, 32'h10,   32'h0,        32'h00003344, 1'b0, 2, "LH 0x10"});
        vecs.push_back('{1'b0, 3'b000, 32'h11,   32'h0,        32'h00000033, 1'b0, 2, "LB 0x11"});
        vecs.push_back('{1'b0, 3'b010, 32'h1010, 32'h0,        32'hBEEF3344, 1'b0, 2, "LW 0x1010 alias"});
        vecs.push_back('{1'b0, 3'b010, 32'h11,   32'h0,        32'h0,        1'b1, 1, "LW 0x11 misaligned"});
        foreach (vecs[i]) begin
            applyStimulus(0, vecs[i].op, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                          vecs[i].expRdata, vecs[i].expErr, vecs[i].expLat, vecs[i].tag);
        end

        // Reset during the single LATENCY=1 commit cycle must suppress the write
        applyStimulus(0, 1'b1, 3'b010, 32'h30, 32'h11111111, 32'h0, 1'b0, 2, "SW 0x30 first");
        @(negedge clk);
        op[0] = 1'b1; f3[0] = 3'b010; addr[0] = 32'h30; wdata[0] = 32'h22222222; reqValid[0] = 1'b1;
        @(negedge clk);
        reqValid[0] = 1'b0;
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        checkOutput("commit rst ready", 32'(reqReady[0]), 32'd1);
        checkOutput("commit rst busy", 32'(busy[0]), 32'd0);
        applyStimulus(0, 1'b0, 3'b010, 32'h30, 32'h0, 32'h11111111, 1'b0, 2, "LW 0x30 after commit rst");

        // Reset while in RESP drops the response
        @(negedge clk);
        op[0] = 1'b0; f3[0] = 3'b010; addr[0] = 32'h30; reqValid[0] = 1'b1;
        @(negedge clk);
        reqValid[0] = 1'b0;
        @(negedge clk);
        checkOutput("resp before rst", 32'(respValid[0]), 32'd1);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        checkOutput("resp dropped by rst", 32'(respValid[0]), 32'd0);
        checkOutput("resp rst busy", 32'(busy[0]), 32'd0);

        // Reset one cycle into a LATENCY=3 store aborts it
        applyStimulus(1, 1'b1, 3'b010, 32'h20, 32'h12345678, 32'h0, 1'b0, 4, "L3 SW 0x20");
        @(negedge clk);
        op[1] = 1'b1; f3[1] = 3'b010; addr[1] = 32'h20; wdata[1] = 32'hCAFEF00D; reqValid[1] = 1'b1;
        @(negedge clk);
        reqValid[1] = 1'b0;
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        checkOutput("L3 abort ready", 32'(reqReady[1]), 32'd1);
        applyStimulus(1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h12345678, 1'b0, 4, "L3 LW 0x20 old value");

        applyStimulus(1, 1'b1, 3'b010, 32'h10, 32'hA5A50F0F, 32'h0, 1'b0, 4, "L3 SW 0x10");
        applyStimulus(1, 1'b1, 3'b010, 32'h14, 32'h01234567, 32'h0, 1'b0, 4, "L3 SW 0x14");
        @(negedge clk);
        runBackToBack();

        // Random traffic over a 64-byte window with random upper address bits
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++) begin
                rw = $urandom;
                ra = 32'(w * 4);
                modelRun(d, 1'b1, 3'b010, ra, rw, expR, expE);
                applyStimulus(d, 1'b1, 3'b010, ra, rw, expR, expE, latOf(d) + 1, "fill");
            end
            for (int n = 0; n < 120; n++) begin
                ro = 1'($urandom_range(0, 1));
                rf = 3'($urandom_range(0, 7));
                ra = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
                rw = $urandom;
                modelRun(d, ro, rf, ra, rw, expR, expE);
                applyStimulus(d, ro, rf, ra, rw, expR, expE, expE ? 1 : latOf(d) + 1, "random");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
